// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the boot-time RAM loader.
// The state enum is common to every build; CHK is only reached when RAM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN,
        DATA,
        CHK,
        DONE,
        ERR
    } state_e;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/ram_loader_word_assembler.sv
// Packs incoming bytes little-endian into RAM words.
// A registered word strobe follows the byte that completes a group, or that ends the image.
module word_assembler
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    input  logic                  last_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_valid_o
);

    logic [1:0]            lane_q, lane_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] merged;

    // Unfilled upper lanes of a short final word stay zero because the
    // pack register is cleared every time a word is emitted.
    always_comb begin
        merged                       = pack_q;
        merged[{lane_q, 3'b000} +: 8] = byte_i;
        pack_d                       = pack_q;
        lane_d                       = lane_q;
        word_d                       = word_q;
        valid_d                      = 1'b0;
        if (byte_valid_i) begin
            if (last_i || (lane_q == 2'(WORD_BYTES - 1))) begin
                word_d  = merged;
                valid_d = 1'b1;
                pack_d  = '0;
                lane_d  = '0;
            end else begin
                pack_d = merged;
                lane_d = lane_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q  <= '0;
            pack_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/ram_loader.sv
// Boot loader: length header, payload packed into words written from BASE_ADDR, then CPU release.
// Define RAM_LOADER_CHECKSUM_EN to require a trailing modulo-256 payload checksum byte.
module ram_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          RAM_ADDR_WIDTH = 17,
    parameter int unsigned BASE_ADDR      = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_rst_out,
    output logic                  load_done,
    output logic                  load_err
);

`ifdef RAM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_LOAD = CHK;
`else
    localparam state_e AFTER_LOAD = DONE;
`endif

    state_e                state_q, state_d;
    logic [1:0]            hdr_cnt_q, hdr_cnt_d;
    logic [31:0]           len_q, len_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rx_ready_q, rx_ready_d;
    logic                  done_q, err_q, cpu_rst_q;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic                  accept;
    logic [31:0]           len_full;
    logic [33:0]           end_addr;
    logic                  overflow;
    logic                  payload_byte;
    logic                  last_byte;

    assign accept       = rx_valid && rx_ready_q;
    assign len_full     = {rx_data, len_q[31:8]};
    assign end_addr     = 34'(BASE_ADDR) + 34'(len_full);
    assign overflow     = end_addr > (34'(1) << RAM_ADDR_WIDTH);
    assign payload_byte = accept && (state_q == DATA) && (cnt_q != len_q);
    assign last_byte    = (cnt_q + 32'd1) == len_q;

    // After the last payload byte the FSM lingers one cycle in DATA with
    // rx_ready low while the final word is written, then moves on.
    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
`ifdef RAM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            LEN: begin
                if (accept) begin
                    len_d     = len_full;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
                        if (len_full == 32'd0) begin
                            state_d = AFTER_LOAD;
                        end else if (overflow) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (cnt_q == len_q) begin
                    state_d = AFTER_LOAD;
                end else if (accept) begin
                    cnt_d = cnt_q + 32'd1;
`ifdef RAM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_data;
`endif
                end
            end
`ifdef RAM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = (rx_data == sum_q) ? DONE : ERR;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase

        rx_ready_d = (state_d == LEN) || (state_d == CHK) ||
                     ((state_d == DATA) && (cnt_d != len_d));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= LEN;
            hdr_cnt_q  <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rx_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            rx_ready_q <= rx_ready_d;
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERR);
            cpu_rst_q  <= (state_d != DONE);
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // The address register always points at the word being written and
    // steps forward once that write strobe has been issued.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_q <= ADDR_WIDTH'(BASE_ADDR);
        end else if (mem_wr) begin
            addr_q <= addr_q + ADDR_WIDTH'(WORD_BYTES);
        end
    end

    word_assembler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .byte_valid_i(payload_byte),
        .byte_i      (rx_data),
        .last_i      (last_byte),
        .word_o      (mem_data),
        .word_valid_o(mem_wr)
    );

    assign rx_ready    = rx_ready_q;
    assign mem_addr    = addr_q;
    assign cpu_rst_out = cpu_rst_q;
    assign load_done   = done_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: expected RAM writes are queued as bytes are sent and matched on mem_wr.
// Builds with or without RAM_LOADER_CHECKSUM_EN.
module tb_ram_loader;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int RAW  = 17;
    localparam int BASE = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rxData = 8'h00;
    logic          rxValid = 1'b0;
    logic          rxReady;
    logic          memWr;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memData;
    logic          cpuRst;
    logic          loadDone;
    logic          loadErr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         expQ[$];
    logic [31:0] expAddr = BASE;
    logic [7:0]  payload[$];

    ram_loader #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .RAM_ADDR_WIDTH(RAW),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .rx_data    (rxData),
        .rx_valid   (rxValid),
        .rx_ready   (rxReady),
        .mem_wr     (memWr),
        .mem_addr   (memAddr),
        .mem_data   (memData),
        .cpu_rst_out(cpuRst),
        .load_done  (loadDone),
        .load_err   (loadErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every write strobe must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (memWr === 1'b1) begin
            checkOutput("wr_expected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("wr_addr", 64'(memAddr), 64'(e.addr));
                checkOutput("wr_data", 64'(memData), 64'(e.data));
                checkOutput("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rxValid = 1'b0;
        end
    endtask

    // Offers one byte and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        idle(gap);
        @(negedge clk);
        while (rxReady !== 1'b1 && waited < 20) begin
            rxValid = 1'b0;
            @(negedge clk);
            waited++;
        end
        if (rxReady !== 1'b1) begin
            checkOutput("rx_ready_timeout", 64'(rxReady), 64'd1);
        end else begin
            rxData  = b;
            rxValid = 1'b1;
            @(posedge clk);
            #1;
            rxValid = 1'b0;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst     = 1'b1;
        rxValid = 1'b0;
        @(negedge clk);
        checkOutput("pending_wr_at_reset", 64'(expQ.size()), 64'd0);
        expQ.delete();
        @(negedge clk);
        rst     = 1'b0;
        expAddr = BASE;
    endtask

    task automatic sendHeader(input logic [31:0] len);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(len[8*i +: 8], 0);
        end
    endtask

    // Sends a header and the first nSend payload bytes, queueing the words the loader should write.
    task automatic loadImage(input logic [31:0] len, input int nSend, input int gapMax, input bit badChk);
        logic [31:0] word;
        logic [7:0]  sum;
        logic [7:0]  b;
        word = '0;
        sum  = '0;
        sendHeader(len);
        for (int i = 0; i < nSend; i++) begin
            b = payload[i];
            applyStimulus(b, int'($urandom_range(gapMax, 0)));
            word[8*(i%4) +: 8] = b;
            sum = sum + b;
            if ((i % 4 == 3) || (i == int'(len) - 1)) begin
                expQ.push_back('{expAddr, word, cyc});
                expAddr = expAddr + 32'd4;
                word    = '0;
            end
        end
`ifdef RAM_LOADER_CHECKSUM_EN
        if (nSend == int'(len)) begin
            applyStimulus(badChk ? sum + 8'd1 : sum, 0);
        end
`else
        if (badChk) begin
            sum = '0;
        end
`endif
    endtask

    task automatic checkFinal(input string tag, input bit expDone, input bit expErr);
        idle(4);
        checkOutput({tag, "_done"}, 64'(loadDone), 64'(expDone));
        checkOutput({tag, "_err"}, 64'(loadErr), 64'(expErr));
        checkOutput({tag, "_cpu_rst"}, 64'(cpuRst), 64'(!expDone));
        checkOutput({tag, "_rx_ready"}, 64'(rxReady), 64'd0);
        checkOutput({tag, "_pending"}, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_rx_ready", 64'(rxReady), 64'd0);
        checkOutput("rst_mem_wr", 64'(memWr), 64'd0);
        checkOutput("rst_mem_addr", 64'(memAddr), 64'(BASE));
        checkOutput("rst_mem_data", 64'(memData), 64'd0);
        checkOutput("rst_cpu_rst", 64'(cpuRst), 64'd1);
        checkOutput("rst_done", 64'(loadDone), 64'd0);
        checkOutput("rst_err", 64'(loadErr), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rx_ready_after_rst", 64'(rxReady), 64'd1);

        // Eight bytes: two full words, CPU released after the second write.
        payload = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        loadImage(32'd8, 8, 0, 1'b0);
`ifndef RAM_LOADER_CHECKSUM_EN
        @(negedge clk);
        checkOutput("wr2_strobe", 64'(memWr), 64'd1);
        checkOutput("cpu_rst_during_wr2", 64'(cpuRst), 64'd1);
        @(negedge clk);
        checkOutput("cpu_rst_after_wr2", 64'(cpuRst), 64'd0);
        checkOutput("done_after_wr2", 64'(loadDone), 64'd1);
`endif
        checkFinal("img8", 1'b1, 1'b0);
        rxData  = 8'h5A;
        rxValid = 1'b1;
        repeat (3) @(negedge clk);
        rxValid = 1'b0;
        checkOutput("done_ignores_rx", 64'(rxReady), 64'd0);
        checkOutput("done_sticky", 64'(loadDone), 64'd1);

        // Partial final word is zero-padded.
        doReset();
        payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        loadImage(32'd5, 5, 0, 1'b0);
        checkFinal("img5", 1'b1, 1'b0);

        // Zero-length image.
        doReset();
        loadImage(32'd0, 0, 0, 1'b0);
        @(negedge clk);
        checkOutput("zero_len_done", 64'(loadDone), 64'd1);
        checkFinal("img0", 1'b1, 1'b0);

        // Length one byte past the RAM is rejected.
        doReset();
        sendHeader(32'h0002_0001);
        @(negedge clk);
        checkOutput("ovf_err", 64'(loadErr), 64'd1);
        checkOutput("ovf_rx_ready", 64'(rxReady), 64'd0);
        rxData  = 8'h77;
        rxValid = 1'b1;
        repeat (3) @(negedge clk);
        rxValid = 1'b0;
        checkFinal("ovf", 1'b0, 1'b1);

        // Length exactly filling the RAM is accepted.
        doReset();
        sendHeader(32'h0002_0000);
        @(negedge clk);
        checkOutput("fit_err", 64'(loadErr), 64'd0);
        checkOutput("fit_rx_ready", 64'(rxReady), 64'd1);

        // Reset after six payload bytes: only the first word lands, then a fresh load works.
        doReset();
        payload = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        loadImage(32'd8, 6, 0, 1'b0);
        idle(2);
        doReset();
        checkOutput("midrst_cpu_rst", 64'(cpuRst), 64'd1);
        payload.delete();
        for (int i = 0; i < 8; i++) payload.push_back(8'($urandom));
        loadImage(32'd8, 8, 0, 1'b0);
        checkFinal("reload", 1'b1, 1'b0);

        // Odd length with idle gaps between bytes.
        doReset();
        payload.delete();
        for (int i = 0; i < 13; i++) payload.push_back(8'($urandom));
        loadImage(32'd13, 13, 2, 1'b0);
        checkFinal("img13", 1'b1, 1'b0);

`ifdef RAM_LOADER_CHECKSUM_EN
        doReset();
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        loadImage(32'd4, 4, 0, 1'b0);
        checkFinal("chk_good", 1'b1, 1'b0);
        doReset();
        loadImage(32'd4, 4, 0, 1'b1);
        checkFinal("chk_bad", 1'b0, 1'b1);
`endif

        idle(3);
        checkOutput("final_pending", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
